dct_basis_stream: RTL

//  Runtime-programmable 2-D DCT basis generator that supersedes the fixed per-(k1,k2) cosine LUTs.

---
 rtl/dct_basis_stream.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/dct_basis_stream.sv
// dct_basis_stream: streams the N*N terms of one 2-D DCT basis function from a quarter-wave cosine ROM
module dct_basis_stream #(
   parameter int N     = 8,
   parameter int FRAC  = 8,
   parameter int CFRAC = 12,
   parameter int OUT_W = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [$clog2(N)-1:0]    req_k1,
   input  logic [$clog2(N)-1:0]    req_k2,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_term,
   output logic [$clog2(N)-1:0]    out_n1,
   output logic [$clog2(N)-1:0]    out_n2,
   output logic                    out_last
);
   localparam int KW = $clog2(N);
   localparam int MW = KW + 2;
   localparam int CW = CFRAC + 2;
   localparam int PW = 2 * CFRAC + 2;
   localparam int SH = 2 * CFRAC - FRAC;
   localparam logic [MW-1:0] NN = MW'(N);
   localparam logic [MW-1:0] N2 = MW'(2 * N);
   localparam logic [MW-1:0] N3 = MW'(3 * N);
   localparam logic signed [PW-1:0] HALF = PW'(1) << (SH - 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state;
   logic [KW-1:0] k1, k2, n1, n2;
   logic adv, lastidx;
   logic s1_v, s1_l, s2_v, s2_l;
   logic [MW-1:0] s1_m1, s1_m2;
   logic [KW-1:0] s1_n1, s1_n2, s2_n1, s2_n2;
   logic signed [CW-1:0] qtab [0:N];
   logic signed [CW-1:0] c1, c2, s2_c1, s2_c2;
   logic signed [2*CW-1:0] prod;
   logic signed [PW-1:0] p, pr;
   // Quarter-wave entries are elaboration constants; all are non-negative so +0.5 then truncate rounds
   function automatic logic signed [CW-1:0] qval(input int i);
      real r;
      r = $cos(i * 3.14159265358979323846 / (2.0 * N)) * (2.0 ** CFRAC);
      return CW'($rtoi(r + 0.5));
   endfunction
   // Fold a phase in [0,4N) onto the quarter wave; 4N-m is just -m in MW bits
   function automatic logic [KW:0] qidx(input logic [MW-1:0] m);
      return (KW+1)'(m <= NN ? m : m <= N2 ? N2 - m : m <= N3 ? m - N2 : MW'(0) - m);
   endfunction
   function automatic logic qneg(input logic [MW-1:0] m);
      return m > NN && m <= N3;
   endfunction
   for (genvar i = 0; i <= N; i++) begin : g_q
      assign qtab[i] = qval(i);
   end
   assign adv     = !out_valid || out_ready;
   assign lastidx = n1 == KW'(N - 1) && n2 == KW'(N - 1);
   // ROM lookup with sign fold for both axes
   always_comb begin
      c1 = qneg(s1_m1) ? -qtab[qidx(s1_m1)] : qtab[qidx(s1_m1)];
      c2 = qneg(s1_m2) ? -qtab[qidx(s1_m2)] : qtab[qidx(s1_m2)];
   end
   // Product of the two factors, rounded half up to FRAC fractional bits
   always_comb begin
      prod = s2_c1 * s2_c2;
      p    = prod[PW-1:0];
      pr   = (p + HALF) >>> SH;
   end
   // Request FSM and (n1,n2) issue counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         k1        <= '0;
         k2        <= '0;
         n1        <= '0;
         n2        <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid && req_ready) begin
               k1        <= req_k1;
               k2        <= req_k2;
               n1        <= '0;
               n2        <= '0;
               state     <= RUN;
               req_ready <= 1'b0;
            end
            RUN: if (adv) begin
               n2 <= n2 + KW'(1);
               if (n2 == KW'(N - 1)) n1 <= n1 + KW'(1);
               if (lastidx) state <= DRAIN;
            end
            DRAIN: if (out_valid && out_ready && out_last) begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
   // Three-stage term pipeline; every stage holds while the consumer stalls
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_l      <= 1'b0;
         s1_m1     <= '0;
         s1_m2     <= '0;
         s1_n1     <= '0;
         s1_n2     <= '0;
         s2_v      <= 1'b0;
         s2_l      <= 1'b0;
         s2_c1     <= '0;
         s2_c2     <= '0;
         s2_n1     <= '0;
         s2_n2     <= '0;
         out_valid <= 1'b0;
         out_term  <= '0;
         out_n1    <= '0;
         out_n2    <= '0;
         out_last  <= 1'b0;
      end else if (adv) begin
         s1_v      <= state == RUN;
         s1_l      <= state == RUN && lastidx;
         s1_m1     <= MW'(k1) * MW'({n1, 1'b1});
         s1_m2     <= MW'(k2) * MW'({n2, 1'b1});
         s1_n1     <= n1;
         s1_n2     <= n2;
         s2_v      <= s1_v;
         s2_l      <= s1_v && s1_l;
         s2_c1     <= c1;
         s2_c2     <= c2;
         s2_n1     <= s1_n1;
         s2_n2     <= s1_n2;
         out_valid <= s2_v;
         out_term  <= OUT_W'(pr);
         out_n1    <= s2_n1;
         out_n2    <= s2_n2;
         out_last  <= s2_v && s2_l;
      end
   end
endmodule
